// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared resource: req/release handshake per requestor,
// one-hot registered grant, hold-time watchdog and a sticky protocol-error flag.
module rr_resource_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 revoke,
  output logic                 proto_err
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [N-1:0]    grant_nx;
  logic [OW-1:0]   owner_nx;
  logic [OW-1:0]   last;
  logic [OW-1:0]   last_nx;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_nx;
  logic            busy_nx;
  logic            revoke_nx;
  logic            proto_nx;

  logic [OW-1:0]   cand;
  logic [OW-1:0]   winner;
  logic            win_vld;
  logic [N-1:0]    own_mask;
  logic            rel_multi;
  logic            rel_bad;

  // Priority scan from last+1 upward; descending loop so the nearest requester is assigned last
  always_comb begin
    cand    = '0;
    winner  = '0;
    win_vld = 1'b0;
    for (int i = N; i >= 1; i--) begin
      cand = last + OW'(i);
      if (req[cand]) begin
        winner  = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Any release outside the owner's grant, or more than one release bit, is a protocol violation
  always_comb begin
    own_mask  = N'(1'b1) << owner;
    rel_multi = (rel & (rel - N'(1'b1))) != '0;
    rel_bad   = rel_multi
              || ((state != GRANT) && (|rel))
              || ((state == GRANT) && (|(rel & ~own_mask)));
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    owner_nx  = owner;
    last_nx   = last;
    hold_nx   = hold_cnt;
    revoke_nx = 1'b0;
    proto_nx  = proto_err | rel_bad;

    case (state)
      IDLE: begin
        grant_nx = '0;
        hold_nx  = '0;
        if (win_vld) begin
          state_nx = GRANT;
          grant_nx = N'(1'b1) << winner;
          owner_nx = winner;
        end
      end
      GRANT: begin
        if (rel[owner]) begin
          last_nx  = owner;
          grant_nx = '0;
          state_nx = RECOVER;
        end else if (hold_cnt == HW'(MAX_HOLD)) begin
          last_nx   = owner;
          grant_nx  = '0;
          revoke_nx = 1'b1;
          state_nx  = RECOVER;
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      RECOVER: begin
        grant_nx = '0;
        state_nx = IDLE;
      end
      default: begin
        grant_nx = '0;
        state_nx = IDLE;
      end
    endcase

    busy_nx = |grant_nx;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      last      <= OW'(N - 1);
      hold_cnt  <= '0;
      busy      <= 1'b0;
      revoke    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      owner     <= owner_nx;
      last      <= last_nx;
      hold_cnt  <= hold_nx;
      busy      <= busy_nx;
      revoke    <= revoke_nx;
      proto_err <= proto_nx;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_busy_tracks:   assert property (@(posedge clk) disable iff (rst) busy == (|grant));

endmodule
